pdh_pid: RTL and testbench
==========================

# pdh_pid

Fixed-point PID servo stage that consumes the rotated PDH error sample (the I or Q feed produced by pdh_core) and produces a 14-bit offset-binary DAC code to drive the laser/cavity actuator. It sits directly downstream of pdh_core's IQ rotation and upstream of the DAC write path. It is fully pipelined at one sample per clock, with a saturating integrator, an optional derivative path and output clipping.

## Interface
- OUT_SHIFT, 16: arithmetic right shift applied to the PID sum before clipping.
- DAC_DATA_WIDTH, 14: output code width.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- err_i  in  16  signed error sample (i_feed or q_feed).
- err_valid_i  in  1  err_i qualifier; may be high every cycle.
- setpoint_i  in  16  signed setpoint subtracted from err_i.
- kp_i, ki_i, kd_i  in  16 each  signed gains, Q1.15.
- enable_i  in  1  servo enable.
- hold_i  in  1  freeze integrator (software anti-windup).
- dac_o  out  14  offset-binary code; 14'h2000 = midscale (~0 V).
- out_valid_o  out  1  one-cycle strobe per processed sample.
- sat_o  out  1  qualified with out_valid_o; high when the output was clipped.

## Operation
- S1, on err_valid_i:
  - e = sat16(err_i − setpoint_i), computed at 17 bits.
  - de = sat16(e − e_prev_r); e_prev_r ← e.
- S2:
  - p = kp·e (32b signed).
  - d = kd·de (32b).
  - integ_r ← sat32(integ_r + ki·e), computed at 33 bits; hold_i=1 leaves integ_r unchanged.
- S3:
  - sum = p + integ_r(new) + d (34b).
  - u = sum >>> OUT_SHIFT.
  - Clip u to [−8192, 8191]; sat_o = 1 if clipped.
  - dac_o = u + 8192 (14b).
- Gains, setpoint and hold are sampled in the stage that uses them. A change applies to the next sample reaching that stage; in-flight samples are never recomputed.
- enable_i = 0:
  - integ_r and e_prev_r are forced to 0 every cycle.
  - dac_o ← 14'h2000 and sat_o ← 0 for every sample reaching S3.
  - out_valid_o still strobes.
- enable_i 0→1: the first sample starts from integ_r = 0 and e_prev_r = 0 (no derivative kick beyond e itself).
- Non-valid cycles advance no state: integ_r, e_prev_r and dac_o all hold.

## Timing
- Latency: err_valid_i high in cycle N → out_valid_o high in cycle N+3. Throughput is 1 sample/cycle, with no backpressure.
- dac_o is registered and held between strobes.
- Reset values:
  - dac_o = 14'h2000; out_valid_o = 0; sat_o = 0.
  - integ_r = 0; e_prev_r = 0; all pipeline valid bits = 0.
- Reset mid-stream: in-flight samples are discarded, with no out_valid_o for them. The first sample accepted after reset deasserts appears 3 cycles later.
- Integrator saturation: integ_r sticks at 2^31−1 or −2^31 and never wraps.
- Simultaneous hold_i and enable_i = 0: the enable clear wins.

## Configuration
- PDH_PID_DERIV_EN defined: the derivative path (de, kd multiply, e_prev_r) is built as described.
- PDH_PID_DERIV_EN undefined:
  - d ≡ 0 and kd_i is ignored.
  - e_prev_r is not instantiated.
  - Latency is still 3 cycles.

## Structure
- pdh_pkg holds:
  - DAC_MIDSCALE = 14'h2000; DAC_MIN_S = −8192; DAC_MAX_S = 8191.
  - The Q1.15 gain typedef.
  - Error and integrator widths.
- One sub-module, sat_clip: a parameterised signed saturator (input width, output width). It is reused for the e, de and integ_r saturations and the output clip.

## Test plan
- Proportional: enable=1, kp=16'sh4000, ki=kd=0, setpoint=0, err_i=1000 → 3 cycles later dac_o=14'h20FA (8442), sat_o=0.
- Integrator: kp=kd=0, ki=16'sh0100, err_i=256 every cycle for 5 samples → dac_o = 8193, 8194, 8195, 8196, 8197. Then hold_i=1 for 3 samples → dac_o stays 8197.
- Clipping:
  - kp=16'sh7FFF, err_i=32767 → dac_o=14'h3FFF, sat_o=1.
  - err_i=−32768 → dac_o=14'h0000, sat_o=1.
  - err_i=−32768 with setpoint=32767 → e saturates to −32768; no wrap.
- Derivative: kd=16'sh4000, kp=ki=0, err_i sequence 0, 1000, 1000 → dac_o = 8192, 8442, 8192 with PDH_PID_DERIV_EN. Without it → 8192, 8192, 8192.
- Enable and reset:
  - Integrator wound to 8197 as above, then enable_i=0 for one sample → dac_o=14'h2000.
  - Re-enable with the same stimulus → output restarts at 8193.
  - Assert rst with 2 samples in flight → no out_valid_o for them; dac_o=14'h2000.

Source files
------------

// File: rtl/pdh_pkg.sv
// Shared widths, gain type and DAC constants for the PDH PID servo path.
// Latency: none (constants and types only).
// Backpressure: none (no logic).
package pdh_pkg;
    localparam int ERR_W   = 16;   // error / setpoint sample width
    localparam int GAIN_W  = 16;   // kp/ki/kd width
    localparam int INTEG_W = 32;   // integrator accumulator width
    localparam int SUM_W   = INTEG_W + 2;   // p + integ + d without overflow

    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;
    localparam int          DAC_MIN_S    = -8192;
    localparam int          DAC_MAX_S    = 8191;

    typedef logic signed [GAIN_W-1:0]  gain_t;   // Q1.15 gain
    typedef logic signed [ERR_W-1:0]   err_t;
    typedef logic signed [INTEG_W-1:0] integ_t;
endpackage

// File: rtl/pdh_pid_sat_clip.sv
// Parameterised signed saturator: narrows IN_W to OUT_W, clamping to the output range.
// Latency: combinational.
// Backpressure: none.
module sat_clip #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clipped
);
    // Out of range whenever the bits above the output sign bit disagree with the input sign.
    always_comb begin
        dout    = din[OUT_W-1:0];
        clipped = 1'b0;
        if (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}}) begin
            clipped = 1'b1;
            dout    = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/pdh_pid.sv
// PID servo: rotated PDH error in, 14-bit offset-binary DAC code out; optional derivative via PDH_PID_DERIV_EN.
// Latency: 3 cycles from err_valid_i to out_valid_o, one sample per clock.
// Backpressure: none; every valid input produces exactly one output strobe.
module pdh_pid
    import pdh_pkg::*;
#(
    parameter int OUT_SHIFT      = 16,
    parameter int DAC_DATA_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [ERR_W-1:0]   err_i,
    input  logic                      err_valid_i,
    input  logic signed [ERR_W-1:0]   setpoint_i,
    input  logic signed [GAIN_W-1:0]  kp_i,
    input  logic signed [GAIN_W-1:0]  ki_i,
    input  logic signed [GAIN_W-1:0]  kd_i,
    input  logic                      enable_i,
    input  logic                      hold_i,
    output logic [DAC_DATA_WIDTH-1:0] dac_o,
    output logic                      out_valid_o,
    output logic                      sat_o
);
    // ---------------- S1: error and error difference ----------------
    logic signed [ERR_W:0] diff_e;
    err_t                  e_s1;
    logic                  e_clip;
    err_t                  e_r;
    logic                  v1_r;

    assign diff_e = {err_i[ERR_W-1], err_i} - {setpoint_i[ERR_W-1], setpoint_i};

    sat_clip #(.IN_W(ERR_W + 1), .OUT_W(ERR_W)) u_sat_e (
        .din(diff_e), .dout(e_s1), .clipped(e_clip)
    );

    // S1 register: capture the saturated error only on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            e_r  <= '0;
        end else begin
            v1_r <= err_valid_i;
            if (err_valid_i) e_r <= e_s1;
        end
    end

    integ_t d_s2;

`ifdef PDH_PID_DERIV_EN
    err_t                  e_prev_r;
    err_t                  de_s1;
    err_t                  de_r;
    logic                  de_clip;
    logic signed [ERR_W:0] diff_de;

    assign diff_de = {e_s1[ERR_W-1], e_s1} - {e_prev_r[ERR_W-1], e_prev_r};

    sat_clip #(.IN_W(ERR_W + 1), .OUT_W(ERR_W)) u_sat_de (
        .din(diff_de), .dout(de_s1), .clipped(de_clip)
    );

    // Previous-error tracker; cleared while disabled so re-enable gives no stale kick.
    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            e_prev_r <= '0;
        end else if (err_valid_i) begin
            e_prev_r <= e_s1;
        end
    end

    // S1 register for the error difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_r <= '0;
        end else if (err_valid_i) begin
            de_r <= de_s1;
        end
    end

    assign d_s2 = integ_t'(kd_i) * integ_t'(de_r);

    logic unused_clip;
    assign unused_clip = e_clip ^ de_clip;
`else
    assign d_s2 = '0;

    logic unused_clip;
    assign unused_clip = e_clip ^ (^kd_i);
`endif

    // ---------------- S2: products and integrator ----------------
    integ_t                  p_s2;
    integ_t                  ki_e;
    logic signed [INTEG_W:0] integ_sum;
    integ_t                  integ_next;
    logic                    integ_clip;
    integ_t                  p_r;
    integ_t                  d_r;
    integ_t                  integ_r;
    logic                    v2_r;

    assign p_s2      = integ_t'(kp_i) * integ_t'(e_r);
    assign ki_e      = integ_t'(ki_i) * integ_t'(e_r);
    assign integ_sum = {integ_r[INTEG_W-1], integ_r} + {ki_e[INTEG_W-1], ki_e};

    sat_clip #(.IN_W(INTEG_W + 1), .OUT_W(INTEG_W)) u_sat_integ (
        .din(integ_sum), .dout(integ_next), .clipped(integ_clip)
    );

    // Saturating integrator: disable clears (and beats hold), hold freezes.
    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            integ_r <= '0;
        end else if (v1_r && !hold_i) begin
            integ_r <= integ_next;
        end
    end

    // S2 register for the proportional and derivative terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r <= 1'b0;
            p_r  <= '0;
            d_r  <= '0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                p_r <= p_s2;
                d_r <= d_s2;
            end
        end
    end

    // ---------------- S3: sum, scale, clip, offset ----------------
    logic signed [SUM_W-1:0]          sum_s3;
    logic signed [SUM_W-1:0]          u_s3;
    logic signed [DAC_DATA_WIDTH-1:0] u_clip;
    logic                             u_sat;

    assign sum_s3 = SUM_W'(p_r) + SUM_W'(integ_r) + SUM_W'(d_r);
    assign u_s3   = sum_s3 >>> OUT_SHIFT;

    sat_clip #(.IN_W(SUM_W), .OUT_W(DAC_DATA_WIDTH)) u_clip_out (
        .din(u_s3), .dout(u_clip), .clipped(u_sat)
    );

    // Output register: offset-binary is the clipped two's-complement with its MSB flipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_o       <= DAC_DATA_WIDTH'(DAC_MIDSCALE);
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            out_valid_o <= v2_r;
            if (v2_r) begin
                if (enable_i) begin
                    dac_o <= {~u_clip[DAC_DATA_WIDTH-1], u_clip[DAC_DATA_WIDTH-2:0]};
                    sat_o <= u_sat;
                end else begin
                    dac_o <= DAC_DATA_WIDTH'(DAC_MIDSCALE);
                    sat_o <= 1'b0;
                end
            end
        end
    end

    logic unused_integ_clip;
    assign unused_integ_clip = integ_clip;
endmodule

// File: tb/tb_pdh_pid.sv
// Self-checking bench for pdh_pid: directed scenarios plus randomized bursts against an arithmetic model.
// Latency: expects every output exactly 3 clocks after its input.
// Backpressure: none; inputs are driven freely one cycle at a time.
module tb_pdh_pid;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] err_i, setpoint_i, kp_i, ki_i, kd_i;
    logic               err_valid_i, enable_i, hold_i;
    logic [13:0]        dac_o;
    logic               out_valid_o, sat_o;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    longint m_integ = 0;
    longint m_eprev = 0;

    typedef struct { int dac; bit sat; int due; } exp_t;

    always #5 clk = ~clk;

    pdh_pid dut (
        .clk(clk), .rst(rst), .err_i(err_i), .err_valid_i(err_valid_i),
        .setpoint_i(setpoint_i), .kp_i(kp_i), .ki_i(ki_i), .kd_i(kd_i),
        .enable_i(enable_i), .hold_i(hold_i),
        .dac_o(dac_o), .out_valid_o(out_valid_o), .sat_o(sat_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    // Reference: one sample through the servo equations, using the gains currently driven.
    function automatic void model(input longint err, output int exp_dac, output bit exp_sat);
        longint e, p, d, sum, u;
        if (!enable_i) begin
            m_integ = 0; m_eprev = 0;
            exp_dac = 8192; exp_sat = 1'b0;
            return;
        end
        e = clampl(err - setpoint_i, -32768, 32767);
`ifdef PDH_PID_DERIV_EN
        d = kd_i * clampl(e - m_eprev, -32768, 32767);
        m_eprev = e;
`else
        d = 0;
`endif
        p = kp_i * e;
        if (!hold_i) m_integ = clampl(m_integ + ki_i * e, -64'sd2147483648, 64'sd2147483647);
        sum = p + m_integ + d;
        u = sum >>> 16;
        exp_sat = (u > 8191) || (u < -8192);
        u = clampl(u, -8192, 8191);
        exp_dac = int'(u + 8192);
    endfunction

    // Drive one valid sample and collect its output strobe (lat = -1 if none within 8 clocks).
    task automatic send_one(input logic signed [15:0] e, output logic [13:0] dac, output logic sat, output int lat);
        err_i = e; err_valid_i = 1'b1;
        lat = -1; dac = 'x; sat = 1'bx;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            step();
            err_valid_i = 1'b0;
            if (out_valid_o) begin lat = k; dac = dac_o; sat = sat_o; end
        end
    endtask

    task automatic clear_state();
        enable_i = 1'b0;
        step(); step();
        enable_i = 1'b1;
        m_integ = 0; m_eprev = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_valid_i = 1'b0; err_i = '0; setpoint_i = '0;
        kp_i = '0; ki_i = '0; kd_i = '0; enable_i = 1'b1; hold_i = 1'b0;
        repeat (3) step();
        n_vec++; if (dac_o !== 14'h2000) begin n_bad++; $display("FAIL reset_dac got %h want 2000", dac_o); end
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        n_vec++; if (sat_o !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", sat_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_proportional();
        logic [13:0] d; logic s; int l;
        kp_i = 16'sh4000; ki_i = '0; kd_i = '0; setpoint_i = '0;
        send_one(16'sd1000, d, s, l);
        n_vec++; if (l !== 3) begin n_bad++; $display("FAIL prop_latency got %0d want 3", l); end
        n_vec++; if (d !== 14'h20FA) begin n_bad++; $display("FAIL prop_dac got %h want 20fa", d); end
        n_vec++; if (s !== 1'b0) begin n_bad++; $display("FAIL prop_sat got %b want 0", s); end
    endtask

    task automatic test_integrator();
        logic [13:0] d; logic s; int l;
        clear_state();
        kp_i = '0; kd_i = '0; ki_i = 16'sh0100; setpoint_i = '0;
        for (int i = 0; i < 5; i++) begin
            send_one(16'sd256, d, s, l);
            n_vec++; if (l !== 3 || d !== 14'(8193 + i)) begin n_bad++; $display("FAIL integ_ramp[%0d] got %0d lat %0d want %0d lat 3", i, d, l, 8193 + i); end
        end
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_one(16'sd256, d, s, l);
            n_vec++; if (d !== 14'd8197) begin n_bad++; $display("FAIL integ_hold[%0d] got %0d want 8197", i, d); end
        end
        hold_i = 1'b0;
    endtask

    task automatic test_enable();
        logic [13:0] d; logic s; int l;
        enable_i = 1'b0;
        send_one(16'sd256, d, s, l);
        n_vec++; if (l !== 3) begin n_bad++; $display("FAIL disabled_strobe got lat %0d want 3", l); end
        n_vec++; if (d !== 14'h2000 || s !== 1'b0) begin n_bad++; $display("FAIL disabled_dac got %h sat %b want 2000 sat 0", d, s); end
        enable_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_one(16'sd256, d, s, l);
            n_vec++; if (d !== 14'(8193 + i)) begin n_bad++; $display("FAIL reenable[%0d] got %0d want %0d", i, d, 8193 + i); end
        end
    endtask

    task automatic test_clip();
        logic [13:0] d; logic s; int l;
        clear_state();
        kp_i = 16'sh7FFF; ki_i = '0; kd_i = '0; setpoint_i = '0;
        send_one(16'sd32767, d, s, l);
        n_vec++; if (d !== 14'h3FFF || s !== 1'b1) begin n_bad++; $display("FAIL clip_hi got %h sat %b want 3fff sat 1", d, s); end
        send_one(-16'sd32768, d, s, l);
        n_vec++; if (d !== 14'h0000 || s !== 1'b1) begin n_bad++; $display("FAIL clip_lo got %h sat %b want 0000 sat 1", d, s); end
        setpoint_i = 16'sd32767;
        send_one(-16'sd32768, d, s, l);
        n_vec++; if (d !== 14'h0000 || s !== 1'b1) begin n_bad++; $display("FAIL err_sat got %h sat %b want 0000 sat 1", d, s); end
        setpoint_i = '0;
    endtask

    task automatic test_derivative();
        logic [13:0] d; logic s; int l;
        int want [3];
        logic signed [15:0] seq [3];
        seq = '{16'sd0, 16'sd1000, 16'sd1000};
`ifdef PDH_PID_DERIV_EN
        want = '{8192, 8442, 8192};
`else
        want = '{8192, 8192, 8192};
`endif
        clear_state();
        kp_i = '0; ki_i = '0; kd_i = 16'sh4000; setpoint_i = '0;
        for (int i = 0; i < 3; i++) begin
            send_one(seq[i], d, s, l);
            n_vec++; if (d !== 14'(want[i])) begin n_bad++; $display("FAIL deriv[%0d] got %0d want %0d", i, d, want[i]); end
        end
        kd_i = '0;
    endtask

    task automatic test_integ_sat();
        logic [13:0] d; logic s; int l; int ed; bit es;
        clear_state();
        kp_i = '0; kd_i = '0; ki_i = 16'sh7FFF; setpoint_i = '0;
        for (int i = 0; i < 8; i++) begin
            logic signed [15:0] e;
            e = (i < 5) ? 16'sd32767 : -16'sd32768;
            model(e, ed, es);
            send_one(e, d, s, l);
            n_vec++; if (d !== 14'(ed) || s !== es) begin n_bad++; $display("FAIL integ_sat[%0d] got %0d sat %b want %0d sat %b", i, d, s, ed, es); end
        end
        ki_i = '0;
    endtask

    task automatic test_reset_midstream();
        logic [13:0] d; logic s; int l;
        enable_i = 1'b1; kp_i = 16'sh4000; ki_i = '0; kd_i = '0; setpoint_i = '0;
        err_i = 16'sd1000; err_valid_i = 1'b1;
        step(); step();
        err_valid_i = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush_valid[0] got %b want 0", out_valid_o); end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush_valid[%0d] got %b want 0", i, out_valid_o); end
        end
        n_vec++; if (dac_o !== 14'h2000) begin n_bad++; $display("FAIL rst_flush_dac got %h want 2000", dac_o); end
        send_one(16'sd1000, d, s, l);
        n_vec++; if (l !== 3 || d !== 14'h20FA) begin n_bad++; $display("FAIL post_rst got %h lat %0d want 20fa lat 3", d, l); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t ex;
        int   last_dac = 0;
        bit   have_last = 1'b0;
        int   ed; bit es;
        logic vld;
        logic signed [15:0] e;
        clear_state();
        for (int b = 0; b < 25; b++) begin
            kp_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
            ki_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 128) - 64);
            kd_i = 16'($urandom_range(0, 8000) - 4000);
            setpoint_i = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
            enable_i = ($urandom_range(0, 7) != 0);
            hold_i   = ($urandom_range(0, 7) == 0);
            if (!enable_i) begin m_integ = 0; m_eprev = 0; end
            for (int c = 0; c < 34; c++) begin
                vld = (c < 30) && ($urandom_range(0, 3) != 0);
                e = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
                err_valid_i = vld; err_i = e;
                if (vld) begin
                    model(e, ed, es);
                    ex.dac = ed; ex.sat = es; ex.due = cyc + 3;
                    q.push_back(ex);
                end
                step();
                if (out_valid_o) begin
                    n_vec++;
                    if (q.size() == 0) begin
                        n_bad++; $display("FAIL rnd_spurious got strobe at cycle %0d want none", cyc);
                    end else begin
                        ex = q.pop_front();
                        if (ex.due != cyc || dac_o !== 14'(ex.dac) || sat_o !== ex.sat) begin
                            n_bad++;
                            $display("FAIL rnd_out got %0d sat %b at cycle %0d want %0d sat %b at cycle %0d",
                                     dac_o, sat_o, cyc, ex.dac, ex.sat, ex.due);
                        end
                        last_dac = ex.dac; have_last = 1'b1;
                    end
                end else if (have_last) begin
                    n_vec++;
                    if (dac_o !== 14'(last_dac)) begin n_bad++; $display("FAIL rnd_hold got %0d want %0d", dac_o, last_dac); end
                end
            end
            err_valid_i = 1'b0;
        end
        n_vec++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_missing got %0d outstanding want 0", q.size()); end
        hold_i = 1'b0; enable_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integrator();
        test_enable();
        test_clip();
        test_derivative();
        test_integ_sat();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
